// File: rtl/pipe_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipe_adder_pkg
//   Shared constants and helpers for the pipelined adder.
//   - DEF_WIDTH / DEF_SEG : default operand width and bits added per stage
//   - num_stages()        : pipeline depth for a given width/segment size
//   - cfg_ok()            : legality of a width/segment pair (used by the top
//                           level to stop elaboration on a bad configuration)
// -----------------------------------------------------------------------------
package pipe_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

  function automatic int num_stages(input int width, input int seg);
    return width / seg;
  endfunction

  // WIDTH must split into a whole number (at least one) of SEG-bit segments.
  function automatic bit cfg_ok(input int width, input int seg);
    return (seg > 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// -----------------------------------------------------------------------------
// pipe_adder_if
//   Handshake bundle between a producer/consumer and the pipelined adder.
//   Input side : in_valid, in_ready, a, b, ci
//   Output side: out_valid, out_ready, s, co
//   Modports:
//     master - the environment (drives operands, accepts results)
//     slave  - the adder itself
// -----------------------------------------------------------------------------
interface pipe_adder_if
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, s, co
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, s, co
  );

endinterface

// File: rtl/pipe_adder_seg.sv
// -----------------------------------------------------------------------------
// adder_seg
//   SEG-bit ripple-carry adder built from gate-level full-adder cells.
//   Ports:
//     a, b [SEG-1:0] : segment operands
//     ci             : carry into bit 0 of the segment
//     s  [SEG-1:0]   : segment sum
//     co             : carry out of the top bit of the segment
//   Purely combinational; one instance sits in every pipeline stage.
// -----------------------------------------------------------------------------
module adder_seg #(
  parameter int SEG = 4
) (
  input  wire [SEG-1:0] a,
  input  wire [SEG-1:0] b,
  input  wire           ci,
  output wire [SEG-1:0] s,
  output wire           co
);

  genvar gi;
  for (gi = 0; gi < SEG; gi++) begin : g_bit
    wire cin;
    wire p;
    wire g_ab;
    wire g_pc;
    wire cout;

    // Each cell takes its carry from the cell below; bit 0 takes ci.
    if (gi == 0) begin : g_cin
      assign cin = ci;
    end else begin : g_cin
      assign cin = g_bit[gi-1].cout;
    end

    xor u_xor_p (p, a[gi], b[gi]);
    xor u_xor_s (s[gi], p, cin);
    and u_and_g (g_ab, a[gi], b[gi]);
    and u_and_p (g_pc, p, cin);
    or  u_or_c  (cout, g_ab, g_pc);
  end

  assign co = g_bit[SEG-1].cout;

endmodule

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
//   Pipelined unsigned adder: {co, s} = a + b + ci, one SEG-bit segment added
//   per stage, STAGES = WIDTH/SEG stages, carry registered between stages.
//   Valid/ready on both sides; full throughput, backpressure via out_ready.
//   Ports:
//     clk   : clock, all state on the rising edge
//     rst_n : asynchronous active-low reset (drops all in-flight results)
//     bus   : pipe_adder_if.slave (in_valid/in_ready/a/b/ci,
//             out_valid/out_ready/s/co)
//   Build option:
//     PIPE_ADDER_SAT_EN - when the final carry-out is 1, s saturates to all
//                         ones (co still reports the overflow). Without it s
//                         wraps modulo 2^WIDTH. Timing is identical.
// -----------------------------------------------------------------------------
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_adder_if.slave   bus
);

  localparam int STAGES = num_stages(WIDTH, SEG);

  if (!cfg_ok(WIDTH, SEG)) begin : g_cfg_err
    $error("pipe_adder: WIDTH must be a positive multiple of SEG");
  end

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] ready;

  // ready_k = !valid_k || ready_{k+1}, evaluated from the output end back to
  // the input so an empty slot anywhere lets everything upstream advance.
  always_comb begin
    logic rdy;
    rdy   = bus.out_ready;
    ready = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy      = !stage_valid[k] || rdy;
      ready[k] = rdy;
    end
  end

  assign bus.in_ready = ready[0];

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * SEG;     // first bit of this stage's segment
    localparam int BW = WIDTH - LO;   // operand-b bits not yet consumed

    // x holds finished sum bits below LO and untouched operand-a bits above;
    // b only keeps the part still to be added, so it shrinks each stage.
    logic             valid_q, valid_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [BW-1:0]    b_q, b_d;

    logic             src_valid;
    logic             src_carry;
    logic [WIDTH-1:0] src_x;
    logic [BW-1:0]    src_b;

    logic [SEG-1:0]   seg_s;
    logic             seg_co;
    logic [WIDTH-1:0] x_fwd;

    if (gi == 0) begin : g_src
      assign src_valid = bus.in_valid;
      assign src_x     = bus.a;
      assign src_b     = bus.b;
      assign src_carry = bus.ci;
    end else begin : g_src
      assign src_valid = g_stage[gi-1].valid_q;
      assign src_x     = g_stage[gi-1].x_fwd;
      assign src_b     = g_stage[gi-1].b_q[BW+SEG-1:SEG];
      assign src_carry = g_stage[gi-1].seg_co;
    end

    assign stage_valid[gi] = valid_q;

    // Data only moves when a real transfer happens, so a stalled result at
    // the output keeps s/co steady.
    always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      x_d     = x_q;
      b_d     = b_q;
      if (ready[gi]) begin
        valid_d = src_valid;
        if (src_valid) begin
          carry_d = src_carry;
          x_d     = src_x;
          b_d     = src_b;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        x_q     <= '0;
        b_q     <= '0;
      end else begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        x_q     <= x_d;
        b_q     <= b_d;
      end
    end

    adder_seg #(
      .SEG (SEG)
    ) u_seg (
      .a  (x_q[LO +: SEG]),
      .b  (b_q[SEG-1:0]),
      .ci (carry_q),
      .s  (seg_s),
      .co (seg_co)
    );

    // Word handed to the next stage: this segment's operand-a bits replaced
    // by their sum.
    always_comb begin
      x_fwd             = x_q;
      x_fwd[LO +: SEG]  = seg_s;
    end
  end

  logic [WIDTH-1:0] sum_raw;
  logic             co_raw;

  assign sum_raw       = g_stage[STAGES-1].x_fwd;
  assign co_raw        = g_stage[STAGES-1].seg_co;
  assign bus.out_valid = g_stage[STAGES-1].valid_q;
  assign bus.co        = co_raw;

`ifdef PIPE_ADDER_SAT_EN
  assign bus.s = co_raw ? {WIDTH{1'b1}} : sum_raw;
`else
  assign bus.s = sum_raw;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  localparam int W   = 16;
  localparam int SG  = 4;
  localparam int LAT = W / SG;
`ifdef PIPE_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(W)) bus ();

  pipe_adder #(.WIDTH(W), .SEG(SG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
  } res_t;

  vec_t vecs [12];
  res_t expq [$];
  logic [W-1:0] drv_s;
  logic         drv_co;
  int total   = 0;
  int bad     = 0;
  int emitted = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] sat_adj(input logic [W-1:0] s, input logic co);
    return (SAT && co) ? {W{1'b1}} : s;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic [W-1:0] es, input logic eco);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.ci       = ci;
    drv_s        = sat_adj(es, eco);
    drv_co       = eco;
  endtask

  // One clock of scoreboard-tracked traffic; called at a negedge after driving.
  task automatic cycle(input string tag);
    res_t r;
    #1;
    if (bus.in_valid && bus.in_ready) begin
      r.s  = drv_s;
      r.co = drv_co;
      expq.push_back(r);
      $display("%s: accept a=%h b=%h ci=%0b", tag, bus.a, bus.b, bus.ci);
    end
    if (bus.out_valid && bus.out_ready) begin
      emitted++;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s_spurious: got s=%h co=%0b, required no output", tag, bus.s, bus.co);
      end else begin
        r = expq.pop_front();
        $display("%s: emit s=%h co=%0b", tag, bus.s, bus.co);
        chk({tag, "_s"}, 32'(bus.s), 32'(r.s));
        chk({tag, "_co"}, 32'(bus.co), 32'(r.co));
      end
    end
    @(negedge clk);
  endtask

  // Single transaction with latency measurement; out_ready must be high.
  task automatic single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [W-1:0] es, input logic eco);
    int lat;
    drive(1'b1, a, b, ci, es, eco);
    #1;
    chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    $display("%s: a=%h b=%h ci=%0b -> s=%h co=%0b latency=%0d", name, a, b, ci, bus.s, bus.co, lat);
    chk({name, "_lat"}, 32'(lat), 32'(LAT));
    chk({name, "_s"}, 32'(bus.s), 32'(drv_s));
    chk({name, "_co"}, 32'(bus.co), 32'(drv_co));
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] es [8];
    logic         eco [8];
    logic [W-1:0] hold_s;
    logic         hold_co;
    logic [W:0]   full;
    logic [W-1:0] ra, rb;
    logic         rc;

    vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2]  = '{16'h7FFF, 16'h8000, 1'b1, 16'h0000, 1'b1};
    vecs[3]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[4]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[6]  = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[8]  = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0};
    vecs[9]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
    vecs[10] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[11] = '{16'h1357, 16'h2468, 1'b1, 16'h37C0, 1'b0};

    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    bus.out_ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_s", 32'(bus.s), 32'd0);
    chk("rst_co", 32'(bus.co), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;

    // Directed table, one transaction at a time with latency check
    for (int i = 0; i < 12; i++) begin
      single($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co);
    end

    // Eight back-to-back random inputs: results on consecutive cycles from LAT
    for (int c = 0; c < 8 + LAT + 3; c++) begin
      if (c >= LAT && c < LAT + 8) begin
        $display("b2b c=%0d: s=%h co=%0b valid=%0b", c, bus.s, bus.co, bus.out_valid);
        chk($sformatf("b2b_valid_c%0d", c), 32'(bus.out_valid), 32'd1);
        chk($sformatf("b2b_s_c%0d", c), 32'(bus.s), 32'(es[c-LAT]));
        chk($sformatf("b2b_co_c%0d", c), 32'(bus.co), 32'(eco[c-LAT]));
      end else begin
        chk($sformatf("b2b_idle_c%0d", c), 32'(bus.out_valid), 32'd0);
      end
      if (c < 8) begin
        ra   = W'($urandom);
        rb   = W'($urandom);
        rc   = 1'($urandom_range(1));
        full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
        es[c]  = sat_adj(full[W-1:0], full[W]);
        eco[c] = full[W];
        drive(1'b1, ra, rb, rc, full[W-1:0], full[W]);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Backpressure: fill with out_ready low, stall, then release
    bus.out_ready = 1'b0;
    expq.delete();
    emitted = 0;
    for (int i = 0; i < LAT; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co);
      cycle("bp_fill");
    end
    drive(1'b1, vecs[4].a, vecs[4].b, vecs[4].ci, vecs[4].s, vecs[4].co);
    #1;
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_head_s", 32'(bus.s), 32'(sat_adj(vecs[0].s, vecs[0].co)));
    hold_s  = bus.s;
    hold_co = bus.co;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold");
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_s", 32'(bus.s), 32'(hold_s));
      chk("bp_hold_co", 32'(bus.co), 32'(hold_co));
      chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    cycle("bp_release");
    bus.in_valid = 1'b0;
    for (int i = 0; i < LAT + 4; i++) cycle("bp_drain");
    chk("bp_emitted", 32'(emitted), 32'd5);
    chk("bp_queue_empty", 32'(expq.size()), 32'd0);

    // Reset while two transactions are in flight (one parked at the output)
    bus.out_ready = 1'b0;
    for (int i = 3; i < 5; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co);
      cycle("mid_fill");
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle("mid_wait");
    chk("mid_pre_valid", 32'(bus.out_valid), 32'd1);
    chk("mid_pre_s", 32'(bus.s), 32'h5555);
    #1;
    rst_n = 1'b0;
    #1;
    $display("mid_rst: out_valid=%0b s=%h co=%0b", bus.out_valid, bus.s, bus.co);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_s", 32'(bus.s), 32'd0);
    chk("mid_rst_co", 32'(bus.co), 32'd0);
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mid_post_idle", 32'(bus.out_valid), 32'd0);
    end
    single("mid_new", vecs[2].a, vecs[2].b, vecs[2].ci, vecs[2].s, vecs[2].co);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
